// File: rtl/seq_run_detector_if.sv
// Signal bundle for seq_run_detector: sample inputs from the source side,
// detection flags and debug state back from the detector.
interface seq_run_detector_if #(
  parameter int CNT_W = 4
);
  logic             en;
  logic             w;
  logic             led_out;
  logic             counter_rst;
  logic             match_ones;
  logic             match_zeros;
  logic [CNT_W-1:0] run_cnt;
  logic [2:0]       state;

  modport master (
    output en, w,
    input  led_out, counter_rst, match_ones, match_zeros, run_cnt, state
  );

  modport slave (
    input  en, w,
    output led_out, counter_rst, match_ones, match_zeros, run_cnt, state
  );
endinterface

// File: rtl/seq_run_detector.sv
// Run detector: flags RUN_LEN equal consecutive samples of w (ones or zeros)
// and holds led_out high for HOLD_CYCLES clocks, optionally retriggering.
module seq_run_detector #(
  parameter int RUN_LEN     = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4,
  parameter int OVERLAP     = 1
) (
  input  logic               clk,
  input  logic               resetn,
  seq_run_detector_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    RUN  = 3'b001,
    HOLD = 3'b010
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX   = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_PRE   = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_w_q, last_w_d;
  logic             led_q, led_d;
  logic             crst_q, crst_d;
  logic             ones_q, ones_d;
  logic             zeros_q, zeros_d;

  logic             track;
  logic             same;
  logic             complete;

  // NOTE: every registered signal is written with <= in the clocked block
  // only; the combinational block below computes all next values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      hold_cnt_q <= '0;
      last_w_q   <= 1'b0;
      led_q      <= 1'b0;
      crst_q     <= 1'b0;
      ones_q     <= 1'b0;
      zeros_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      last_w_q   <= last_w_d;
      led_q      <= led_d;
      crst_q     <= crst_d;
      ones_q     <= ones_d;
      zeros_q    <= zeros_d;
    end
  end

  // NOTE: each output of this block gets a default before the case so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    hold_cnt_d = hold_cnt_q;
    last_w_d   = last_w_q;
    led_d      = led_q;
    ones_d     = ones_q;
    zeros_d    = zeros_q;
    crst_d     = 1'b0;
    same       = (bus.w == last_w_q);
    complete   = 1'b0;
    // Overlapping mode keeps tracking runs while a detection is held.
    track      = (state_q == RUN) || ((state_q == HOLD) && (OVERLAP != 0));

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          last_w_d  = bus.w;
          run_cnt_d = CNT_ONE;
          crst_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN, HOLD: begin
        if (state_q == HOLD && hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end

        if (track && bus.en) begin
          if (same) begin
            complete = (run_cnt_q == RUN_PRE) ||
                       ((OVERLAP != 0) && (run_cnt_q == RUN_MAX));
            if (run_cnt_q < RUN_MAX) begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end else begin
            last_w_d  = bus.w;
            run_cnt_d = CNT_ONE;
            crst_d    = 1'b1;
          end
        end

        // A completion on the final hold cycle retriggers instead of exiting.
        if (complete) begin
          state_d    = HOLD;
          led_d      = 1'b1;
          hold_cnt_d = HOLD_LOAD;
          ones_d     = last_w_q;
          zeros_d    = ~last_w_q;
          if (OVERLAP == 0) begin
            run_cnt_d = '0;
          end
        end else if (state_q == HOLD && hold_cnt_q == '0) begin
          led_d   = 1'b0;
          ones_d  = 1'b0;
          zeros_d = 1'b0;
          state_d = (OVERLAP != 0) ? RUN : IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        run_cnt_d  = '0;
        hold_cnt_d = '0;
        last_w_d   = 1'b0;
        led_d      = 1'b0;
        ones_d     = 1'b0;
        zeros_d    = 1'b0;
      end
    endcase
  end

  assign bus.led_out     = led_q;
  assign bus.counter_rst = crst_q;
  assign bus.match_ones  = ones_q;
  assign bus.match_zeros = zeros_q;
  assign bus.run_cnt     = run_cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_seq_run_detector.sv
// Directed bench for seq_run_detector: a vector table for single-edge
// behaviour plus hand-written sequences for hold length, retrigger and reset.
module tb_seq_run_detector;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_RUN  = 3'b001;
  localparam logic [2:0] S_HOLD = 3'b010;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_run_detector_if #(.CNT_W(4)) if_ovl ();
  seq_run_detector_if #(.CNT_W(4)) if_novl ();
  seq_run_detector_if #(.CNT_W(4)) if_h1 ();

  seq_run_detector #(.RUN_LEN(4), .HOLD_CYCLES(8), .CNT_W(4), .OVERLAP(1))
    u_ovl  (.clk(clk), .resetn(resetn), .bus(if_ovl));
  seq_run_detector #(.RUN_LEN(4), .HOLD_CYCLES(8), .CNT_W(4), .OVERLAP(0))
    u_novl (.clk(clk), .resetn(resetn), .bus(if_novl));
  seq_run_detector #(.RUN_LEN(4), .HOLD_CYCLES(1), .CNT_W(4), .OVERLAP(1))
    u_h1   (.clk(clk), .resetn(resetn), .bus(if_h1));

  // Observation word: {led, counter_rst, ones, zeros, run_cnt[3:0], state[2:0]}
  typedef struct {
    logic        rst;
    logic        en;
    logic        w;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic w,
                              input logic led, input logic crst,
                              input logic mo, input logic mz,
                              input logic [3:0] rc, input logic [2:0] st);
    vec_t v;
    v.rst = rst;
    v.en  = en;
    v.w   = w;
    v.exp = {led, crst, mo, mz, rc, st};
    return v;
  endfunction

  function automatic logic [10:0] obs_ovl();
    return {if_ovl.led_out, if_ovl.counter_rst, if_ovl.match_ones,
            if_ovl.match_zeros, if_ovl.run_cnt, if_ovl.state};
  endfunction

  function automatic logic [10:0] obs_novl();
    return {if_novl.led_out, if_novl.counter_rst, if_novl.match_ones,
            if_novl.match_zeros, if_novl.run_cnt, if_novl.state};
  endfunction

  function automatic logic [10:0] obs_h1();
    return {if_h1.led_out, if_h1.counter_rst, if_h1.match_ones,
            if_h1.match_zeros, if_h1.run_cnt, if_h1.state};
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    if_ovl.en  = 1'b0;
    if_novl.en = 1'b0;
    if_h1.en   = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Structural invariants on the match flags, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      n_vec++;
      if ((if_ovl.match_ones && if_ovl.match_zeros) ||
          ((if_ovl.match_ones || if_ovl.match_zeros) && !if_ovl.led_out) ||
          ((if_novl.match_ones || if_novl.match_zeros) && !if_novl.led_out) ||
          ((if_h1.match_ones || if_h1.match_zeros) && !if_h1.led_out)) begin
        n_err++;
        $display("FAIL match_invariant at %0t", $time);
      end
    end
  end

  initial begin
    int first_on, last_on, on_cnt, rc5, rc6, max_rc;

    if_ovl.en = 1'b0;  if_ovl.w = 1'b0;
    if_novl.en = 1'b0; if_novl.w = 1'b0;
    if_h1.en = 1'b0;   if_h1.w = 1'b0;

    // Asynchronous reset with no clock edge in between.
    #1 resetn = 1'b0;
    #1;
    check("reset_ovl",  32'(obs_ovl()),  32'd0);
    check("reset_novl", 32'(obs_novl()), 32'd0);
    check("reset_h1",   32'(obs_h1()),   32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Ones run completes, zeros restart during hold, run resumes after exit.
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 4'd1, S_RUN));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4'd2, S_RUN));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4'd3, S_RUN));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 4'd4, S_HOLD));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 4'd1, S_HOLD));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 4'd2, S_HOLD));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 4'd3, S_HOLD));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd3, S_HOLD));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd3, S_HOLD));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd3, S_HOLD));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 4'd3, S_HOLD));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'd3, S_RUN));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 4'd4, S_HOLD));
    // 1,1,1,0,0,0,0: polarity change in RUN, zeros match.
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 4'd1, S_RUN));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4'd2, S_RUN));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4'd3, S_RUN));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 4'd1, S_RUN));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'd2, S_RUN));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'd3, S_RUN));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 4'd4, S_HOLD));
    // en toggling: only qualified edges count.
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 4'd1, S_RUN));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'd1, S_RUN));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4'd2, S_RUN));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'd2, S_RUN));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4'd3, S_RUN));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'd3, S_RUN));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0, 4'd4, S_HOLD));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      if_ovl.en = vecs[i].en;
      if_ovl.w  = vecs[i].w;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 32'(obs_ovl()), 32'(vecs[i].exp));
    end

    // Continuing the en-toggle case: the hold counts clocks, not samples.
    if_ovl.en = 1'b0;
    on_cnt = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (if_ovl.led_out) on_cnt++;
    end
    check("en_hold_clocks", 32'(on_cnt), 32'd8);

    // Six ones with overlap: retrigger at samples 5 and 6.
    do_reset();
    first_on = -1; last_on = -1; on_cnt = 0; max_rc = 0;
    for (int i = 1; i <= 20; i++) begin
      if_ovl.en = (i <= 6);
      if_ovl.w  = 1'b1;
      @(posedge clk);
      #1;
      if (if_ovl.led_out) begin
        on_cnt++;
        if (first_on < 0) first_on = i;
        last_on = i;
      end
      if (int'(if_ovl.run_cnt) > max_rc) max_rc = int'(if_ovl.run_cnt);
    end
    check("ovl_first_on", 32'(first_on), 32'd4);
    check("ovl_last_on",  32'(last_on),  32'd13);
    check("ovl_on_cnt",   32'(on_cnt),   32'd10);
    check("ovl_rc_sat",   32'(max_rc),   32'd4);
    check("ovl_exit_state", 32'(if_ovl.state), 32'(S_RUN));
    if_ovl.en = 1'b0;

    // Same stimulus without overlap: extra samples ignored, back to IDLE.
    do_reset();
    first_on = -1; last_on = -1; on_cnt = 0; rc5 = -1; rc6 = -1;
    for (int i = 1; i <= 20; i++) begin
      if_novl.en = (i <= 6);
      if_novl.w  = 1'b1;
      @(posedge clk);
      #1;
      if (if_novl.led_out) begin
        on_cnt++;
        if (first_on < 0) first_on = i;
        last_on = i;
      end
      if (i == 5) rc5 = int'(if_novl.run_cnt);
      if (i == 6) rc6 = int'(if_novl.run_cnt);
    end
    check("novl_first_on", 32'(first_on), 32'd4);
    check("novl_last_on",  32'(last_on),  32'd11);
    check("novl_on_cnt",   32'(on_cnt),   32'd8);
    check("novl_rc_e5",    32'(rc5),      32'd0);
    check("novl_rc_e6",    32'(rc6),      32'd0);
    check("novl_exit_state", 32'(if_novl.state), 32'(S_IDLE));
    if_novl.en = 1'b0;

    // HOLD_CYCLES=1: a single-cycle pulse.
    do_reset();
    first_on = -1; on_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if_h1.en = (i <= 4);
      if_h1.w  = 1'b0;
      @(posedge clk);
      #1;
      if (if_h1.led_out) begin
        on_cnt++;
        if (first_on < 0) first_on = i;
        check("h1_zeros_flag", 32'(if_h1.match_zeros), 32'd1);
      end
    end
    check("h1_first_on", 32'(first_on), 32'd4);
    check("h1_on_cnt",   32'(on_cnt),   32'd1);
    check("h1_exit_state", 32'(obs_h1()), 32'({7'b0000100, S_RUN}));
    if_h1.en = 1'b0;

    // Asynchronous reset mid-HOLD, then detection from IDLE again.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      if_ovl.en = (i <= 4);
      if_ovl.w  = 1'b1;
      @(posedge clk);
      #1;
    end
    check("pre_areset_hold", 32'(obs_ovl()), 32'({4'b1010, 4'd4, S_HOLD}));
    #2 resetn = 1'b0;
    #1;
    check("areset_mid_hold", 32'(obs_ovl()), 32'd0);
    #1 resetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if_ovl.en = 1'b1;
      if_ovl.w  = 1'b1;
      @(posedge clk);
      #1;
      if (i == 1)
        check("post_areset_e1", 32'(obs_ovl()), 32'({4'b0100, 4'd1, S_RUN}));
    end
    check("post_areset_match", 32'(obs_ovl()), 32'({4'b1010, 4'd4, S_HOLD}));
    if_ovl.en = 1'b0;

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
